hi_lo_unit: RTL and testbench
=============================

// Module: hi_lo_unit
// PURPOSE
//  Multiply/divide execution unit and architectural HI/LO register pair, in the EX stage.
//  Serves the mult/div/mthi/mtlo requests that the decode stage issues.
//  Returns committed HI/LO to decode on hi_lo_ds_bus, plus a pending flag that decode uses to stall mfhi/mflo.
//  Multiplies are pipelined with fixed latency; divides are iterative, radix-2, non-restoring.
// PARAMETERS
//  MUL_LAT       2   multiply latency in cycles (legal 1..4)
//  DIV_ZERO_FAST 1   1: divide-by-zero completes in 1 cycle; 0: runs the full 33 cycles
// PORTS
//  clk           in   1   clock, rising edge
//  resetn        in   1   asynchronous, active-low reset
//  req_valid     in   1   request valid
//  req_ready     out  1   unit can accept a request
//  req_op        in   3   1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 ignored
//  req_src1      in   32  rs value (dividend / multiplicand / mthi, mtlo data)
//  req_src2      in   32  rt value (divisor / multiplier)
//  flush         in   1   cancel any in-flight operation
//  busy          out  1   operation in flight
//  hi_lo_pending out  1   HI/LO will change; decode must stall mfhi/mflo
//  done          out  1   one-cycle pulse: new HI/LO visible this cycle
//  hi_lo_ds_bus  out  64  {HI[31:0], LO[31:0]} committed values
// BEHAVIOUR
//  Reset (asynchronous):
//   - HI=LO=0, FSM enters IDLE, busy=0, done=0, hi_lo_pending=0.
//   - A reset during an operation aborts it; HI/LO read 0.
//  Handshake:
//   - req_ready = (state==IDLE) && !flush.
//   - A request is accepted when req_valid && req_ready. The acceptance cycle is cycle 0.
//   - Operands are registered at acceptance; req_src1/req_src2 are don't-care afterwards.
//   - op 0 and op 7 are accepted and dropped: no state change, no done pulse.
//  Commit timing:
//   - HI/LO update at the end of cycle k; done=1 and the new value on hi_lo_ds_bus in cycle k+1.
//   - mthi/mtlo: k=0; the other register is unchanged.
//   - mult/multu: k=MUL_LAT; {HI,LO} = 64-bit product (signed or unsigned).
//   - div/divu: k=33 (cycles 1..32 iterate, cycle 33 does sign fixup); LO=quotient, HI=remainder.
//  FSM:
//   - IDLE -> MUL (count MUL_LAT) -> IDLE.
//   - IDLE -> DIV (count 0..32) -> IDLE.
//   - mthi/mtlo stay in IDLE.
//  Status outputs:
//   - busy = hi_lo_pending = (state!=IDLE).
//   - done is registered and never overlaps busy for the same operation.
//  Signed divide:
//   - Iterate on operand magnitudes.
//   - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
//   - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=src1; k=1 if DIV_ZERO_FAST else k=33.
//  Flush:
//   - Synchronous, highest priority over completion.
//   - Flush high in any cycle <= k -> FSM to IDLE, HI/LO unchanged, no done pulse.
//   - Flush in cycle k+1 has no effect on the already-committed value.
//  Back-to-back: a new request is accepted in cycle k+1 (the done cycle) at the earliest.
// TESTING
//  1. mthi 0x12345678, next cycle mtlo 0x9ABCDEF0 -> done twice; bus ends 0x12345678_9ABCDEF0.
//  2. mult 0xFFFFFFFE x 3 -> bus = 0xFFFFFFFF_FFFFFFFA exactly MUL_LAT+1 cycles after acceptance;
//     multu with the same operands -> 0x00000002_FFFFFFFA.
//  3. div 0xFFFFFFF9(-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, done at cycle 34;
//     req_ready=0 and pending=1 during cycles 1..33.
//  4. divu 100/0 with DIV_ZERO_FAST=1 -> done at cycle 2, LO=0xFFFFFFFF, HI=100;
//     div 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  5. div accepted, flush at cycle 20 -> IDLE at cycle 21, no done, HI/LO unchanged;
//     req_valid held with flush -> not accepted.
//  6. resetn low at cycle 10 of a divu -> HI=LO=0, busy=0 asynchronously;
//     first request after release is accepted normally.

Source files
------------

// File: rtl/hi_lo_unit.sv
// hi_lo_unit: EX-stage multiply/divide unit owning the architectural HI/LO pair
module hi_lo_unit #(
    parameter int MUL_LAT       = 2,
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        busy,
    output logic        hi_lo_pending,
    output logic        done,
    output logic [63:0] hi_lo_ds_bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, dvs_q, dvs_d, quo_q, quo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [33:0] rem_q, rem_d;
    logic        sgn_q, sgn_d, done_q, done_d;

    logic        accept, a_neg, b_neg, div_zero, mul_fin, div_fin;
    logic [63:0] prod;
    logic [33:0] rem_sh, rem_step, rem_fix;
    logic [31:0] quo_out, rem_out;

    assign req_ready     = (state_q == IDLE) && !flush;
    assign accept        = req_valid && req_ready;
    assign busy          = state_q != IDLE;
    assign hi_lo_pending = busy;
    assign done          = done_q;
    assign hi_lo_ds_bus  = {hi_q, lo_q};
    assign div_zero      = b_q == 32'd0;
    assign mul_fin       = (state_q == MUL) && (cnt_q == 6'(MUL_LAT));
    assign div_fin       = (state_q == DIV) && ((cnt_q == 6'd33) || (DIV_ZERO_FAST && div_zero));

    // Datapath: 64-bit product, one non-restoring divide step, final remainder/sign fixup
    always_comb begin
        a_neg    = sgn_q & a_q[31];
        b_neg    = sgn_q & b_q[31];
        prod     = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
        rem_sh   = {rem_q[32:0], quo_q[31]};
        rem_step = rem_q[33] ? rem_sh + {2'b00, dvs_q} : rem_sh - {2'b00, dvs_q};
        rem_fix  = rem_q[33] ? rem_q + {2'b00, dvs_q} : rem_q;
        quo_out  = (a_neg ^ b_neg) ? -quo_q : quo_q;
        rem_out  = a_neg ? -rem_fix[31:0] : rem_fix[31:0];
    end

    // Next state: accept in IDLE, flush aborts, otherwise count/iterate until commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = 6'd1;
            if (accept) begin
                a_d     = req_src1;
                b_d     = req_src2;
                sgn_d   = (req_op == 3'd1) || (req_op == 3'd3);
                dvs_d   = (sgn_d && req_src2[31]) ? -req_src2 : req_src2;
                quo_d   = (sgn_d && req_src1[31]) ? -req_src1 : req_src1;
                rem_d   = '0;
                state_d = (req_op == 3'd1 || req_op == 3'd2) ? MUL :
                          (req_op == 3'd3 || req_op == 3'd4) ? DIV : IDLE;
                hi_d    = (req_op == 3'd5) ? req_src1 : hi_q;
                lo_d    = (req_op == 3'd6) ? req_src1 : lo_q;
                done_d  = (req_op == 3'd5) || (req_op == 3'd6);
            end
        end else if (flush) begin
            state_d = IDLE;
        end else if (mul_fin) begin
            {hi_d, lo_d} = prod;
            done_d       = 1'b1;
            state_d      = IDLE;
        end else if (div_fin) begin
            hi_d    = div_zero ? a_q : rem_out;
            lo_d    = div_zero ? 32'hFFFF_FFFF : quo_out;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (state_q == DIV) begin
            rem_d = rem_step;
            quo_d = {quo_q[30:0], ~rem_step[33]};
        end
    end

    // State and data registers; reset clears HI/LO and abandons any operation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit: directed bench with a cycle-level result model for hi_lo_unit
module tb_hi_lo_unit;
    localparam int MUL_LAT = 2;
    localparam bit DZF     = 1'b1;

    logic        clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, flush = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_src1 = '0, req_src2 = '0;
    logic        req_ready, busy, hi_lo_pending, done;
    logic [63:0] hi_lo_ds_bus;

    int checks = 0, errors = 0;
    bit started = 1'b0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] p_res;
    int          m_left;
    logic        m_done;

    hi_lo_unit #(.MUL_LAT(MUL_LAT), .DIV_ZERO_FAST(DZF)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .busy(busy), .hi_lo_pending(hi_lo_pending), .done(done), .hi_lo_ds_bus(hi_lo_ds_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // {HI,LO} result of a mult/div request computed with plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, m;
        logic [63:0] ua, ub, uq, um, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        if (op == 3'd1) r = 64'(sa * sb);
        else if (op == 3'd2) r = ua * ub;
        else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (op == 3'd3) begin
            q = sa / sb;
            m = sa % sb;
            r = {m[31:0], q[31:0]};
        end else begin
            uq = ua / ub;
            um = ua % ub;
            r  = {um[31:0], uq[31:0]};
        end
        return r;
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd1 || op == 3'd2) return MUL_LAT + 1;
        if (b == 32'd0 && DZF) return 2;
        return 34;
    endfunction

    // Model: m_left counts the busy cycles still ahead; results land when it runs out
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; p_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                if (flush) m_left <= 0;
                else if (m_left == 1) begin
                    {m_hi, m_lo} <= p_res;
                    m_done <= 1'b1;
                    m_left <= 0;
                end else m_left <= m_left - 1;
            end else if (req_valid && !flush) begin
                if (req_op == 3'd5) begin m_hi <= req_src1; m_done <= 1'b1; end
                else if (req_op == 3'd6) begin m_lo <= req_src1; m_done <= 1'b1; end
                else if (req_op >= 3'd1 && req_op <= 3'd4) begin
                    p_res  <= ref_res(req_op, req_src1, req_src2);
                    m_left <= latency(req_op, req_src2) - 1;
                end
            end
        end
    end

    // Compare every cycle outside reset
    always @(negedge clk) begin
        if (started && resetn) begin
            chk("busy", busy, m_left > 0);
            chk("pending", hi_lo_pending, m_left > 0);
            chk("ready", req_ready, (m_left == 0) && !flush);
            chk("done", done, m_done);
            chk("bus", hi_lo_ds_bus, {m_hi, m_lo});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        @(posedge clk);
        #2 req_valid = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            c++;
            if (done) break;
        end
    endtask

    logic [2:0]  v_op[8]  = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd3, 3'd1};
    logic [31:0] v_a[8]   = '{32'hFFFFFFFF, 32'd7, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'd7};
    logic [31:0] v_b[8]   = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF};

    initial begin
        int c, nd;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        started = 1'b1;
        @(negedge clk);
        chk("rst_bus", hi_lo_ds_bus, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", req_ready, 1'b1);

        issue(3'd5, 32'h12345678, 32'd0);
        issue(3'd6, 32'h9ABCDEF0, 32'd0);
        @(negedge clk);
        chk("mtlo_done", done, 1'b1);
        chk("mthi_mtlo_bus", hi_lo_ds_bus, 64'h12345678_9ABCDEF0);

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done(c);
        chk("mult_lat", c, 3);
        chk("mult_bus", hi_lo_ds_bus, 64'hFFFFFFFF_FFFFFFFA);
        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        wait_done(c);
        chk("multu_lat", c, 3);
        chk("multu_bus", hi_lo_ds_bus, 64'h00000002_FFFFFFFA);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_done(c);
        chk("div_lat", c, 34);
        chk("div_bus", hi_lo_ds_bus, 64'hFFFFFFFF_FFFFFFFD);

        issue(3'd4, 32'd100, 32'd0);
        wait_done(c);
        chk("divz_lat", c, 2);
        chk("divz_bus", hi_lo_ds_bus, 64'h00000064_FFFFFFFF);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_done(c);
        chk("divovf_lat", c, 34);
        chk("divovf_bus", hi_lo_ds_bus, 64'h00000000_80000000);

        for (int i = 0; i < 8; i++) begin
            issue(v_op[i], v_a[i], v_b[i]);
            wait_done(c);
            chk("vec_lat", c, latency(v_op[i], v_b[i]));
        end
        chk("vec_last_bus", hi_lo_ds_bus, 64'hFFFFFFFF_FFFFFFF9);

        issue(3'd3, 32'd1000, 32'd7);
        repeat (19) @(posedge clk);
        #2 begin flush = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'hDEADBEEF; end
        @(posedge clk);
        @(negedge clk);
        chk("flush_idle", busy, 1'b0);
        chk("flush_ready", req_ready, 1'b0);
        @(posedge clk);
        #2 begin flush = 1'b0; req_valid = 1'b0; end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("flush_nodone", nd, 0);
        chk("flush_bus", hi_lo_ds_bus, 64'hFFFFFFFF_FFFFFFF9);

        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_pending", hi_lo_pending, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_bus", hi_lo_ds_bus, 64'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        issue(3'd5, 32'hCAFEF00D, 32'd0);
        @(negedge clk);
        chk("post_rst_done", done, 1'b1);
        chk("post_rst_bus", hi_lo_ds_bus, 64'hCAFEF00D_00000000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
